// File: rtl/instr_encoder.sv
// RV32 field packer (I-load, S, R, B) feeding a small FIFO that streams words into instruction memory.
// Optional INSTR_ENC_OPCODE_CHECK_EN: drop unsupported opcodes and pulse enc_err instead of pushing them.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [4:0]               rd,
    input  logic [11:0]              imm,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic                     flush,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     enc_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]      packed_word;
    logic             accept;
    logic             push;
    logic             pop;
    logic             empty;

    // Unknown opcodes fall through to the R-type layout.
    always_comb begin
        packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
        case (opcode)
            OP_LOAD:   packed_word = {imm, rs1, funct3, rd, opcode};
            OP_STORE:  packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OP_OP:     packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_BRANCH: packed_word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
            default:   packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

    assign empty    = (cnt_q == '0);
    assign in_ready = (cnt_q != CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = !empty && mem_ready && !flush;

`ifdef INSTR_ENC_OPCODE_CHECK_EN
    logic known;
    logic enc_err_q;

    always_comb begin
        known = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_OP, OP_BRANCH: known = 1'b1;
            default:                             known = 1'b0;
        endcase
    end

    assign push = accept && known;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_err_q <= 1'b0;
        end else begin
            enc_err_q <= accept && !known;
        end
    end

    assign enc_err = enc_err_q;
`else
    assign push    = accept;
    assign enc_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            addr_q <= ADDR_W'(BASE_ADDR);
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            addr_q <= ADDR_W'(BASE_ADDR);
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= packed_word;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign mem_we    = !empty;
    assign mem_addr  = addr_q;
    assign mem_wdata = empty ? '0 : fifo_mem[rd_ptr];
    assign count     = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing table, back-to-back stream, full/stall, wrap, flush, reset.
module tb_instr_encoder;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        logic [31:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        flush;
    logic        mem_ready;

    logic        in_ready, mem_we, enc_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  count;

    logic        in_ready2, mem_we2, enc_err2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  count2;

    int errors = 0;
    int checks = 0;

    vec_t vecs[8];
    vec_t unk;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .funct3(funct3), .funct7(funct7), .flush(flush),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .count(count), .enc_err(enc_err)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .funct3(funct3), .funct7(funct7), .flush(flush),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_ready(mem_ready), .count(count2), .enc_err(enc_err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_tuple(input vec_t v);
        opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; imm = v.imm; funct7 = v.f7;
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        logic acc;

        //              op          rd  rs1 rs2 f3  imm      f7        word
        vecs[0] = '{7'b0110011,  3,  1,  2, 0, 12'd0,   7'h00, 32'h002081B3}; // add x3,x1,x2
        vecs[1] = '{7'b0000011,  5,  2,  0, 2, 12'd8,   7'h00, 32'h00812283}; // lw x5,8(x2)
        vecs[2] = '{7'b0100011,  0,  2,  6, 2, 12'd12,  7'h00, 32'h00612623}; // sw x6,12(x2)
        vecs[3] = '{7'b1100011,  0,  1,  2, 0, 12'd4,   7'h00, 32'h00208463}; // beq x1,x2,+8
        vecs[4] = '{7'b0110011, 10, 11, 12, 0, 12'd0,   7'h20, 32'h40C58533}; // sub x10,x11,x12
        vecs[5] = '{7'b1100011,  0,  0,  0, 0, 12'hFFF, 7'h00, 32'hFE000FE3}; // B all imm bits
        vecs[6] = '{7'b0100011,  0, 31, 31, 7, 12'hFFF, 7'h00, 32'hFFFFFFA3}; // S all ones
        vecs[7] = '{7'b1100011,  0,  0,  0, 1, 12'h400, 7'h00, 32'h000010E3}; // B imm[10] only
        unk     = '{7'b0010011,  1,  0,  5, 0, 12'd0,   7'h00, 32'h00500093};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        set_tuple(vecs[0]);
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_err", 32'(enc_err), 0);
        chk("rst_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

        // packing table, one word at a time
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_tuple(vecs[i]); in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk("tbl_we", 32'(mem_we), 1);
            chk("tbl_addr", 32'(mem_addr), 32'(i));
            chk("tbl_data", mem_wdata, vecs[i].word);
        end
        @(negedge clk);
        chk("tbl_empty", 32'(count), 0);

        // back-to-back lw, sw, beq
        do_flush();
        for (int k = 0; k < 3; k++) begin
            set_tuple(vecs[k + 1]); in_valid = 1'b1;
            @(negedge clk);
            chk("b2b_we", 32'(mem_we), 1);
            chk("b2b_addr", 32'(mem_addr), 32'(k));
            chk("b2b_data", mem_wdata, vecs[k + 1].word);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drained", 32'(mem_we), 0);

        // fill to full with memory stalled, fifth tuple held upstream
        do_flush();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_tuple(vecs[k]); in_valid = 1'b1;
            chk("fill_ready", 32'(in_ready), 1);
            @(negedge clk);
        end
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(in_ready), 0);
        set_tuple(vecs[4]); in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("stall_count", 32'(count), 4);
        chk("stall_data", mem_wdata, vecs[0].word);
        chk("stall_addr", 32'(mem_addr), 0);
        mem_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (mem_we && mem_ready) begin
                chk("drain_addr", 32'(mem_addr), 32'(got));
                chk("drain_data", mem_wdata, vecs[got].word);
                chk("wrap_addr", 32'(mem_addr2), 32'(got % 4));
                got++;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        chk("drain_done", 32'(got), 5);
        chk("drain_count", 32'(count), 0);
        chk("drain_addr_end", 32'(mem_addr), 5);
        chk("wrap_addr_end", 32'(mem_addr2), 1);
        chk("wrap_count", 32'(count2), 0);

        // flush overriding push and pop
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_tuple(vecs[k]); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_flush_count", 32'(count), 3);
        flush = 1'b1; in_valid = 1'b1; mem_ready = 1'b1;
        set_tuple(vecs[5]);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_we", 32'(mem_we), 0);
        chk("flush_addr", 32'(mem_addr), 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_flush_we", 32'(mem_we), 1);
        chk("post_flush_addr", 32'(mem_addr), 0);
        chk("post_flush_data", mem_wdata, vecs[5].word);
        @(negedge clk);

        // async reset mid-stream
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_tuple(vecs[k]); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_we", 32'(mem_we), 0);
        chk("arst_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // unsupported opcode
        @(negedge clk);
        set_tuple(unk); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef INSTR_ENC_OPCODE_CHECK_EN
        chk("unk_err", 32'(enc_err), 1);
        chk("unk_count", 32'(count), 0);
        chk("unk_ready", 32'(in_ready), 1);
`else
        chk("unk_err", 32'(enc_err), 0);
        chk("unk_count", 32'(count), 1);
        chk("unk_data", mem_wdata, unk.word);
`endif
        @(negedge clk);
        chk("unk_err_pulse", 32'(enc_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
